// File: rtl/draw_pkg.sv
// Shared types and screen geometry for the frame draw sequencer.
package draw_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_FIN     = 3'd4
    } sched_state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
endpackage

// File: rtl/screen_clear.sv
// Raster fill counter: walks every (x, y) of the screen, one pixel per enabled cycle.
module screen_clear
    import draw_pkg::*;
#(
    parameter int XMAX = SCREEN_W,
    parameter int YMAX = SCREEN_H
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);
    logic x_wrap;

    assign x_wrap = (x == X_W'(XMAX - 1));
    assign last   = x_wrap && (y == Y_W'(YMAX - 1));

    // Wrapping after the last pixel leaves the counter at (0,0) for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_wrap) begin
                x <= '0;
                y <= last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/draw_scheduler.sv
// Owns the adapter plot port: clears the screen, then runs each enabled engine in turn.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int NENG = 3,
    parameter int XMAX = SCREEN_W,
    parameter int YMAX = SCREEN_H
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // start is a level request held until done is seen; done holds until start drops.
    input  logic                  start,
    output logic                  done,
    input  logic [COL_W-1:0]      bg_colour,
    input  logic [NENG-1:0]       eng_en,
    output logic [NENG-1:0]       eng_start,
    input  logic [NENG-1:0]       eng_done,
    input  logic [X_W*NENG-1:0]   eng_x,
    input  logic [Y_W*NENG-1:0]   eng_y,
    input  logic [COL_W*NENG-1:0] eng_colour,
    input  logic [NENG-1:0]       eng_plot,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [COL_W-1:0]      vga_colour,
    output logic                  vga_plot,
    output logic [2:0]            state_dbg
);
    localparam int IDX_W = (NENG > 1) ? $clog2(NENG) : 1;

    sched_state_t     state, state_nxt;
    logic [IDX_W-1:0] cur_idx, idx_nxt;
    logic [X_W-1:0]   clr_x;
    logic [Y_W-1:0]   clr_y;
    logic             clr_last;
    int               search_lo;
    int               sel;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    assign state_dbg = state;
    assign sel       = int'(cur_idx);

    screen_clear #(.XMAX(XMAX), .YMAX(YMAX)) u_clear (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == S_CLEAR),
        .x    (clr_x),
        .y    (clr_y),
        .last (clr_last)
    );

    // Lowest enabled engine at or above search_lo; disabled engines cost no cycles.
    assign search_lo = (state == S_CLEAR) ? 0 : sel + 1;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NENG - 1; i >= 0; i--) begin
            if (eng_en[i] && (i >= search_lo)) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cur_idx <= '0;
        end else begin
            state   <= state_nxt;
            cur_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = cur_idx;
        case (state)
            S_IDLE:    if (start) state_nxt = S_CLEAR;
            S_CLEAR: begin
                if (clr_last) begin
                    state_nxt = pick_found ? S_RUN : S_FIN;
                    idx_nxt   = pick_idx;
                end
            end
            S_RUN:     if (eng_done[cur_idx]) state_nxt = S_RELEASE;
            S_RELEASE: begin
                state_nxt = pick_found ? S_RUN : S_FIN;
                idx_nxt   = pick_idx;
            end
            S_FIN:     if (!start) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        done       = 1'b0;
        eng_start  = '0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        case (state)
            S_CLEAR: begin
                vga_plot   = 1'b1;
                vga_x      = clr_x;
                vga_y      = clr_y;
                vga_colour = bg_colour;
            end
            S_RUN: begin
                eng_start[cur_idx] = 1'b1;
                vga_x      = eng_x[sel*X_W +: X_W];
                vga_y      = eng_y[sel*Y_W +: Y_W];
                vga_colour = eng_colour[sel*COL_W +: COL_W];
                vga_plot   = eng_plot[cur_idx];
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with three stub engines that plot five pixels each.
module tb_draw_scheduler;
    import draw_pkg::*;

    localparam int NENG   = 3;
    localparam int NPIX   = SCREEN_W * SCREEN_H;
    localparam int EPLOTS = 5;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  done;
    logic [COL_W-1:0]      bg_colour;
    logic [NENG-1:0]       eng_en;
    logic [NENG-1:0]       eng_start;
    logic [NENG-1:0]       eng_done;
    logic [X_W*NENG-1:0]   eng_x;
    logic [Y_W*NENG-1:0]   eng_y;
    logic [COL_W*NENG-1:0] eng_colour;
    logic [NENG-1:0]       eng_plot;
    logic [X_W-1:0]        vga_x;
    logic [Y_W-1:0]        vga_y;
    logic [COL_W-1:0]      vga_colour;
    logic                  vga_plot;
    logic [2:0]            state_dbg;

    logic                  rogue;
    logic [2:0]            cnt [NENG];

    int checks = 0;
    int errors = 0;

    draw_scheduler #(.NENG(NENG), .XMAX(SCREEN_W), .YMAX(SCREEN_H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (done),
        .bg_colour (bg_colour),
        .eng_en    (eng_en),
        .eng_start (eng_start),
        .eng_done  (eng_done),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .eng_colour(eng_colour),
        .eng_plot  (eng_plot),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub engines: plot EPLOTS pixels while started, done with the last one, re-arm when released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NENG; i++) begin
                if (eng_start[i] && cnt[i] < 3'(EPLOTS)) cnt[i] <= cnt[i] + 1'b1;
                else if (!eng_start[i]) cnt[i] <= '0;
            end
        end
    end

    // A rogue engine 1 shouts plot/done with x=0xEE whenever it is not the started one.
    always_comb begin
        eng_plot   = '0;
        eng_done   = '0;
        eng_x      = '0;
        eng_y      = '0;
        eng_colour = '0;
        for (int i = 0; i < NENG; i++) begin
            if (rogue && i == 1 && !eng_start[i]) begin
                eng_plot[i]             = 1'b1;
                eng_done[i]             = 1'b1;
                eng_x[8*i +: 8]         = 8'hEE;
                eng_y[7*i +: 7]         = 7'h55;
                eng_colour[3*i +: 3]    = 3'b111;
            end else begin
                eng_plot[i]             = eng_start[i] && (cnt[i] < 3'(EPLOTS));
                eng_done[i]             = eng_start[i] && (cnt[i] == 3'(EPLOTS - 1));
                eng_x[8*i +: 8]         = 8'(40 * i + int'(cnt[i]));
                eng_y[7*i +: 7]         = 7'(30 * i + int'(cnt[i]));
                eng_colour[3*i +: 3]    = 3'(i + 1 + int'(cnt[i]));
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; bg_colour = '0; eng_en = '0; rogue = 1'b0;
        #1;
        checks++;
        if (vga_plot !== 1'b0 || done !== 1'b0 || eng_start !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: plot=%b done=%b start=%b, want 0 0 000", vga_plot, done, eng_start);
        end
        checks++;
        if (vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0 || state_dbg !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL reset_fields: x=%0d y=%0d c=%0d st=%0d, want 0 0 0 %0d",
                     vga_x, vga_y, vga_colour, state_dbg, S_IDLE);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'(S_IDLE) || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: st=%0d plot=%b, want %0d 0", state_dbg, vga_plot, S_IDLE);
        end
    endtask

    // Raise start at a negedge and check all XMAX*YMAX clear pixels in raster order.
    task automatic test_clear(input logic [2:0] bg, input bit drop_start);
        int ex, ey;
        bg_colour = bg;
        checks++;
        if (vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL idle_plot: got %b want 0", vga_plot);
        end
        start = 1'b1;
        ex = 0; ey = 0;
        for (int p = 0; p < NPIX; p++) begin
            @(negedge clk);
            checks++;
            if (vga_plot !== 1'b1 || vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_colour !== bg) begin
                errors++;
                $display("FAIL clear_pixel %0d: plot=%b x=%0d y=%0d c=%0d, want 1 %0d %0d %0d",
                         p, vga_plot, vga_x, vga_y, vga_colour, ex, ey, bg);
            end
            if (drop_start && p == 100) start = 1'b0;
            if (ex == SCREEN_W - 1) begin
                ex = 0;
                ey = ey + 1;
            end else begin
                ex = ex + 1;
            end
        end
    endtask

    // Called right after the last clear pixel: expects each enabled engine in turn, then done.
    task automatic test_engines(input logic [2:0] en_mask);
        logic [2:0] exp_start_q[$];
        int         exp_eng_q[$];
        int         exp_k_q[$];
        int         nplots;
        nplots = 0;
        for (int i = 0; i < NENG; i++) begin
            if (en_mask[i]) begin
                for (int k = 0; k < EPLOTS; k++) begin
                    exp_start_q.push_back(3'(1 << i));
                    exp_eng_q.push_back(i);
                    exp_k_q.push_back(k);
                end
                exp_start_q.push_back(3'b000);
                exp_eng_q.push_back(-1);
                exp_k_q.push_back(-1);
            end
        end
        for (int c = 0; c < exp_start_q.size(); c++) begin
            @(negedge clk);
            checks++;
            if (eng_start !== exp_start_q[c] || vga_plot !== (exp_k_q[c] >= 0)) begin
                errors++;
                $display("FAIL eng_seq cycle %0d: start=%b plot=%b, want %b %b",
                         c, eng_start, vga_plot, exp_start_q[c], exp_k_q[c] >= 0);
            end
            if (exp_k_q[c] >= 0) begin
                nplots++;
                checks++;
                if (vga_x !== 8'(40 * exp_eng_q[c] + exp_k_q[c]) ||
                    vga_y !== 7'(30 * exp_eng_q[c] + exp_k_q[c]) ||
                    vga_colour !== 3'(exp_eng_q[c] + 1 + exp_k_q[c])) begin
                    errors++;
                    $display("FAIL eng_pixel e%0d k%0d: x=%0d y=%0d c=%0d, want %0d %0d %0d",
                             exp_eng_q[c], exp_k_q[c], vga_x, vga_y, vga_colour,
                             8'(40 * exp_eng_q[c] + exp_k_q[c]), 7'(30 * exp_eng_q[c] + exp_k_q[c]),
                             3'(exp_eng_q[c] + 1 + exp_k_q[c]));
                end
            end
        end
        checks++;
        if (nplots != EPLOTS * $countones(en_mask)) begin
            errors++;
            $display("FAIL eng_plot_count: got %0d want %0d", nplots, EPLOTS * $countones(en_mask));
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || vga_plot !== 1'b0 || eng_start !== 3'b000) begin
            errors++;
            $display("FAIL fin_entry: done=%b plot=%b start=%b, want 1 0 000", done, vga_plot, eng_start);
        end
    endtask

    // In FIN: done holds while start is high, falls one cycle after start drops.
    task automatic test_finish(input bit start_held);
        if (start_held) begin
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL done_hold: got %b want 1", done);
                end
            end
            start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || state_dbg !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL done_fall: done=%b st=%0d, want 0 %0d", done, state_dbg, S_IDLE);
        end
    endtask

    task automatic test_reset_mid_run();
        bit found;
        eng_en = 3'b111;
        test_clear(3'b010, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (eng_start === 3'b010) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_run1: eng_start never 010 within 40 cycles");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (vga_plot !== 1'b0 || eng_start !== 3'b000 || state_dbg !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL async_reset: plot=%b start=%b st=%0d, want 0 000 %0d",
                     vga_plot, eng_start, state_dbg, S_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'b010) begin
            errors++;
            $display("FAIL restart_first: plot=%b x=%0d y=%0d c=%0d, want 1 0 0 2",
                     vga_plot, vga_x, vga_y, vga_colour);
        end
        @(negedge clk);
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd1 || vga_y !== 7'd0) begin
            errors++;
            $display("FAIL restart_second: plot=%b x=%0d y=%0d, want 1 1 0", vga_plot, vga_x, vga_y);
        end
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();

        // No engines, black background, start dropped mid-clear: done pulses once.
        @(negedge clk);
        eng_en = 3'b000;
        test_clear(3'b000, 1'b1);
        test_engines(3'b000);
        test_finish(1'b0);

        // All engines, rogue engine 1 chattering while engine 0 runs.
        @(negedge clk);
        eng_en = 3'b111;
        rogue  = 1'b1;
        test_clear(3'b101, 1'b0);
        test_engines(3'b111);
        rogue  = 1'b0;
        test_finish(1'b1);

        // Engine 1 disabled: engine 2 follows RELEASE(0) directly.
        @(negedge clk);
        eng_en = 3'b101;
        test_clear(3'b011, 1'b0);
        test_engines(3'b101);
        test_finish(1'b1);

        @(negedge clk);
        test_reset_mid_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Sequencer that owns the VGA adapter's single plot port and drives a complete frame. On `start` it first clears the 160x120 screen to a background colour with its own pixel counter. It then runs up to `NENG` shape engines (e.g. reuleaux, circle) one after another over their start/done handshake, forwarding only the active engine's pixel stream to the adapter. It sits between the drawing engines and `vga_adapter` in the task top level.

## Interface
Parameters:
- `NENG`, 3: number of attached drawing engines; engine 0 runs first.
- `XMAX`, 160: screen width in pixels.
- `YMAX`, 120: screen height in pixels.

Ports:
- `clk`  in  1: system clock (CLOCK_50).
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: level request to draw a frame; held high until `done` is seen.
- `done`  out  1: frame complete; held while `start` stays high.
- `bg_colour`  in  3: clear colour.
- `eng_en`  in  NENG: per-engine enable; a 0 bit skips that engine.
- `eng_start`  out  NENG: one-hot start to the engines.
- `eng_done`  in  NENG: engine done flags.
- `eng_x`  in  8*NENG: packed engine x; engine i is `[8i+7:8i]`.
- `eng_y`  in  7*NENG: packed engine y.
- `eng_colour`  in  3*NENG: packed engine colour.
- `eng_plot`  in  NENG: engine plot strobes.
- `vga_x`  out  8, `vga_y`  out  7, `vga_colour`  out  3, `vga_plot`  out  1: to the adapter.

## Operation
- States: IDLE, CLEAR, RUN(i), RELEASE(i), FIN.
- IDLE: outputs quiescent. `start`=1 moves to CLEAR with x=0, y=0.
- CLEAR: one pixel per cycle. `vga_plot`=1, `vga_colour`=`bg_colour`, and `vga_x`/`vga_y` equal the counter.
  - x increments; at x=XMAX-1 it wraps to 0 and y increments.
  - After pixel (XMAX-1, YMAX-1) the block goes to the first enabled engine, or to FIN if none is enabled.
- RUN(i): `eng_start[i]`=1, all other `eng_start` bits are 0. `vga_*` = engine i's fields, and `vga_plot` = `eng_plot[i]`.
  - On `eng_done[i]`=1 the block goes to RELEASE(i).
  - Any pixel engine i presents in that same cycle is still forwarded.
- RELEASE(i): exactly one cycle. `eng_start` is all 0 and `vga_plot`=0. This lets the engine drop `done` and re-arm.
  - Next state is the next higher enabled engine, or FIN.
- Disabled engines are skipped combinationally when the next index is chosen. They cost no cycles.
- FIN: `done`=1. `start`=0 returns to IDLE. While `start` stays 1, FIN holds.
- `start` falling before FIN is ignored; the frame always completes.
- `eng_done` from a non-active engine is ignored.
- `vga_plot` is 0 in IDLE, RELEASE and FIN. `vga_x`/`vga_y`/`vga_colour` are don't-care there and are driven to 0.
- `eng_en` is sampled only at each next-engine decision.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE, counters 0, `done`=0, `eng_start`=0, `vga_plot`=0, `vga_x`/`vga_y`/`vga_colour`=0.
- Reset mid-frame aborts immediately with no partial flush.
- `start` sampled high at edge k: pixel (0,0) is presented in the cycle after edge k.
- CLEAR lasts exactly XMAX*YMAX = 19200 cycles.
- `eng_start[i]` rises on the edge that ends CLEAR or RELEASE.
- Engine pixel forwarding is combinational, with zero added latency, during RUN.
- `done` rises on the edge after the last RELEASE (or after CLEAR if no engine is enabled). It falls on the edge after `start`=0 is sampled.
- A frame can restart at the earliest one cycle after `done` falls.

## Structure
- Package `draw_pkg`:
  - state enum `sched_state_t`;
  - constants `SCREEN_W`=160, `SCREEN_H`=120;
  - coordinate widths `X_W`=8, `Y_W`=7, `COL_W`=3.
- Sub-module `screen_clear`: the x/y fill counter.
  - Inputs: `clk`, `rst_n`, `en`.
  - Outputs: `x`, `y`, `last`.
  - `last` is high on pixel (XMAX-1, YMAX-1).
- The scheduler contains the FSM, the next-engine priority picker and the output mux.

## Test plan
- Reset, then `start`=1 with `eng_en`=0 and `bg_colour`=3'b000 -> 19200 plot cycles with first (0,0), row wrap (159,0)->(0,1), last (159,119); `done`=1 on the next cycle.
- NENG=3, all enabled, stub engines asserting done after 5 plots each -> `eng_start` sequence 001, 010, 100, each separated by one all-zero cycle. Exactly 15 engine pixels are forwarded with matching x/y/colour.
- `eng_en`=3'b101 -> engine 1 never started; engine 2 starts directly after RELEASE(0).
- Engine 1 asserts `eng_plot` while engine 0 is active -> `vga_plot` unaffected and `vga_x` remains engine 0's value.
- `start` dropped during CLEAR -> the frame still completes; `done` pulses for one cycle, then IDLE.
- `rst_n` pulled low during RUN(1) -> `vga_plot` and `eng_start` go to 0 without waiting for a clock edge. A subsequent `start` restarts at CLEAR pixel (0,0).
